// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg : shared 640x480@60 raster constants and coordinate type
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC;

   // Half-open window test lo <= v < hi, kept at coordinate width.
   function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter : modulo-TOTAL raster axis counter with wrap strobe
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = 800
)(
   input  logic   vga_clk,
   input  logic   reset_n,
   input  logic   inc,
   output coord_t count,
   output coord_t count_next,
   output logic   wrap
);

   localparam coord_t LAST = coord_t'(TOTAL - 1);

   // count_next is exported so the top can decode outputs in step with the counter.
   always_comb begin
      wrap       = inc && (count == LAST);
      count_next = count;
      if (wrap) begin
         count_next = '0;
      end else if (inc) begin
         count_next = count + coord_t'(1);
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen : VGA raster position, sync/blank and frame-level pulses
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
)(
   input  logic        vga_clk,
   input  logic        reset_n,
   output coord_t      DrawX,
   output coord_t      DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count
);

   localparam int     H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int     V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   coord_t      hc;
   coord_t      vc;
   coord_t      hc_next;
   coord_t      vc_next;
   logic        h_wrap;
   logic        v_wrap;
   logic        hs_q;
   logic        vs_q;
   logic        blank_q;
   logic        frame_start_q;
   logic        vblank_start_q;
   logic [15:0] frame_cnt;

   vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcount (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .inc        (1'b1),
      .count      (hc),
      .count_next (hc_next),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcount (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .inc        (h_wrap),
      .count      (vc),
      .count_next (vc_next),
      .wrap       (v_wrap)
   );

   // Decoding the next-state position keeps every output aligned with DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hs_q           <= 1'b1;
         vs_q           <= 1'b1;
         blank_q        <= 1'b1;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         frame_cnt      <= '0;
      end else begin
         hs_q           <= !in_range(hc_next, HS_START, HS_END);
         vs_q           <= !in_range(vc_next, VS_START, VS_END);
         blank_q        <= (hc_next < H_VIS_C) && (vc_next < V_VIS_C);
         frame_start_q  <= v_wrap;
         vblank_start_q <= h_wrap && (vc_next == V_VIS_C);
         if (v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign DrawX        = hc;
   assign DrawY        = vc;
   assign hs           = hs_q;
   assign vs           = vs_q;
   assign blank        = blank_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;
   assign frame_count  = frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen : directed checks on full-size and shrunk raster instances
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;

   coord_t      dx_d, dy_d, dx_s, dy_s;
   logic        hs_d, vs_d, blank_d, fs_d, vbs_d;
   logic        hs_s, vs_s, blank_s, fs_s, vbs_s;
   logic [15:0] fc_d, fc_s;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen dut_d (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .DrawX        (dx_d),
      .DrawY        (dy_d),
      .hs           (hs_d),
      .vs           (vs_d),
      .blank        (blank_d),
      .frame_start  (fs_d),
      .vblank_start (vbs_d),
      .frame_count  (fc_d)
   );

   // Shrunk raster: 15 clocks/line, 11 lines/frame, 165 clocks/frame.
   // hs low for x in 10..12, vs low for y in 7..8, visible 8x6 = 48 clocks.
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
   ) dut_s (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .DrawX        (dx_s),
      .DrawY        (dy_s),
      .hs           (hs_s),
      .vs           (vs_s),
      .blank        (blank_s),
      .frame_start  (fs_s),
      .vblank_start (vbs_s),
      .frame_count  (fc_s)
   );

   typedef struct {
      int   n;
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic blank;
      logic vbs;
      logic fs;
   } vec_t;

   localparam int NVEC   = 14;
   localparam int LAST_N = 1500;

   vec_t tbl [NVEC];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int idx;
      int hs_low_d, hs_low_s, vs_low_s, first_vs_s, blank_s_cnt, vbs_cnt, vbs_at;
      int fs_times[$];
      int fs_early, waited;

      // {n, x, y, hs, vs, blank, vblank_start, frame_start} for the full-size raster
      tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1439, 639, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1456, 656, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1499, 699, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1500, 700, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      hs_low_d = 0; hs_low_s = 0; vs_low_s = 0; first_vs_s = -1;
      blank_s_cnt = 0; vbs_cnt = 0; vbs_at = -1;

      reset_n = 1'b0;
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      check("reset_fc_d", fc_d, 0);
      check("reset_fc_s", fc_s, 0);
      check("reset_fs_s", fs_s, 0);
      check("reset_vbs_s", vbs_s, 0);
      reset_n = 1'b1;

      // Sample n is taken n clocks after the last reset edge; n=0 is (0,0).
      idx = 0;
      for (int n = 0; n <= LAST_N; n++) begin
         if (n > 0) @(negedge vga_clk);
         if (idx < NVEC && tbl[idx].n == n) begin
            check($sformatf("vec%0d_x", idx), dx_d, tbl[idx].x);
            check($sformatf("vec%0d_y", idx), dy_d, tbl[idx].y);
            check($sformatf("vec%0d_hs", idx), hs_d, tbl[idx].hs);
            check($sformatf("vec%0d_vs", idx), vs_d, tbl[idx].vs);
            check($sformatf("vec%0d_blank", idx), blank_d, tbl[idx].blank);
            check($sformatf("vec%0d_vbs", idx), vbs_d, tbl[idx].vbs);
            check($sformatf("vec%0d_fs", idx), fs_d, tbl[idx].fs);
            idx++;
         end
         if (n < 800 && !hs_d) hs_low_d++;
         if (n < 15 && !hs_s) hs_low_s++;
         if (n < 165) begin
            if (!vs_s) begin
               vs_low_s++;
               if (first_vs_s < 0) first_vs_s = n;
            end
            if (blank_s) blank_s_cnt++;
            if (vbs_s) begin
               vbs_cnt++;
               vbs_at = n;
            end
         end
         if (fs_s) begin
            fs_times.push_back(n);
            check($sformatf("fs%0d_count", fs_times.size()), fc_s, fs_times.size());
            check($sformatf("fs%0d_xy", fs_times.size()), {dx_s, dy_s}, 0);
         end
         if (fs_d) check("fs_d_early", fs_d, 0);
      end

      check("vec_table_consumed", idx, NVEC);
      check("hs_low_clocks_d", hs_low_d, 96);
      check("hs_low_clocks_s", hs_low_s, 3);
      check("vs_low_clocks_s", vs_low_s, 30);
      check("vs_first_low_s", first_vs_s, 105);
      check("blank_clocks_s", blank_s_cnt, 48);
      check("vbs_pulses_s", vbs_cnt, 1);
      check("vbs_position_s", vbs_at, 90);
      check("fs_total_s", fs_times.size(), 9);
      check("fs_first_s", (fs_times.size() > 0) ? fs_times[0] : -1, 165);
      check("fs_second_s", (fs_times.size() > 1) ? fs_times[1] : -1, 330);
      check("fs_third_s", (fs_times.size() > 2) ? fs_times[2] : -1, 495);
      check("fc_after_run_s", fc_s, 9);

      // Mid-frame reset for one clock: raster restarts, aborted frame not counted.
      reset_n = 1'b0;
      @(negedge vga_clk);
      reset_n = 1'b1;
      check("midrst_xy_d", {dx_d, dy_d}, 0);
      check("midrst_xy_s", {dx_s, dy_s}, 0);
      check("midrst_fc_s", fc_s, 0);
      check("midrst_fs_s", fs_s, 0);
      fs_early = 0;
      for (int k = 1; k < 165; k++) begin
         @(negedge vga_clk);
         if (fs_s) fs_early++;
      end
      check("midrst_no_early_fs", fs_early, 0);
      @(negedge vga_clk);
      check("midrst_fs_at_165", fs_s, 1);
      check("midrst_fc_at_165", fc_s, 1);
      check("midrst_xy_at_165", {dx_s, dy_s}, 0);

      // Counter rollover 65535 -> 0 coinciding with frame_start.
      @(negedge vga_clk);
      force dut_s.frame_cnt = 16'hFFFF;
      @(negedge vga_clk);
      release dut_s.frame_cnt;
      check("wrap_preload", fc_s, 16'hFFFF);
      waited = 0;
      while (!fs_s && waited < 200) begin
         @(negedge vga_clk);
         waited++;
      end
      check("wrap_fs_seen", fs_s, 1);
      check("wrap_fc_zero", fc_s, 0);
      check("wrap_wait_len", waited, 163);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
